// File: rtl/rr_grant_decoder.sv
// Round-robin grant stage that sits after an external priority encoder.
// It latches the encoder's winner, holds the grant until release or timeout, then advances the priority pointer.
module rr_grant_decoder #(
   parameter int REQCNT   = 3,
   parameter int REQWIDTH = $clog2(REQCNT),
   parameter int HOLD_MAX = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [REQCNT-1:0]   req_i,
   input  logic [REQWIDTH-1:0] num_i,
   input  logic [REQCNT-1:0]   done_i,
   output logic [REQWIDTH-1:0] prior_o,
   output logic [REQCNT-1:0]   grant_o,
   output logic [REQWIDTH-1:0] grant_num_o,
   output logic                grant_valid_o,
   output logic                timeout_o
);

   localparam int                  CNTW     = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam logic [CNTW-1:0]     CNT_LAST = (HOLD_MAX > 0) ? CNTW'(HOLD_MAX - 1) : '0;
   localparam logic [REQWIDTH-1:0] LAST_IDX = REQWIDTH'(REQCNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [REQWIDTH-1:0] g_q, g_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [REQWIDTH-1:0] prior_q, prior_d;
   logic [REQCNT-1:0]   grant_q, grant_d;
   logic [REQWIDTH-1:0] grant_num_q, grant_num_d;
   logic                timeout_q, timeout_d;

   logic                num_hit;
   logic [REQCNT-1:0]   num_onehot;
   logic                g_req;
   logic                g_done;
   logic                timed_out;

   // Explicit compare loops keep out-of-range indices (num_i >= REQCNT) from selecting anything.
   always_comb begin
      num_hit    = 1'b0;
      num_onehot = '0;
      g_req      = 1'b0;
      g_done     = 1'b0;
      for (int i = 0; i < REQCNT; i++) begin
         if (num_i == REQWIDTH'(i)) begin
            num_hit       = req_i[i];
            num_onehot[i] = 1'b1;
         end
         if (g_q == REQWIDTH'(i)) begin
            g_req  = req_i[i];
            g_done = done_i[i];
         end
      end
      timed_out = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
   end

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      cnt_d       = cnt_q;
      prior_d     = prior_q;
      grant_d     = grant_q;
      grant_num_d = grant_num_q;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (num_hit) begin
               state_d     = ST_GRANT;
               g_d         = num_i;
               cnt_d       = '0;
               grant_d     = num_onehot;
               grant_num_d = num_i;
            end
         end
         ST_GRANT: begin
            if (g_done || !g_req || timed_out) begin
               state_d     = ST_GAP;
               grant_d     = '0;
               grant_num_d = '0;
               prior_d     = (g_q == LAST_IDX) ? '0 : g_q + REQWIDTH'(1);
               timeout_d   = timed_out && !g_done && g_req;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         ST_GAP: begin
            // One dead cycle lets the encoder see the new prior_o before the next arbitration.
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            grant_d     = '0;
            grant_num_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         g_q         <= '0;
         cnt_q       <= '0;
         prior_q     <= '0;
         grant_q     <= '0;
         grant_num_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         cnt_q       <= cnt_d;
         prior_q     <= prior_d;
         grant_q     <= grant_d;
         grant_num_q <= grant_num_d;
         timeout_q   <= timeout_d;
      end
   end

   assign prior_o       = prior_q;
   assign grant_o       = grant_q;
   assign grant_num_o   = grant_num_q;
   assign grant_valid_o = |grant_q;
   assign timeout_o     = timeout_q;

endmodule
